// File: rtl/uart_tx_arb.sv
// Line-atomic arbiter that shares the UART TX FIFO write port between the
// monitor and the CPU console. Each source has a small private character FIFO.

module uart_tx_arb_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: storage is not reset; count and pointers alone decide which entries
  // are valid, so resetting the array would only add flops.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module uart_tx_arb #(
  parameter int DEPTH   = 4,
  parameter int HOLD_TO = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] mon_char,
  input  logic       mon_en,
  output logic       mon_full,
  input  logic [7:0] cpu_char,
  input  logic       cpu_en,
  output logic       cpu_full,
  input  logic       tx_fifo_full,
  output logic [7:0] tx_wdata,
  output logic       tx_wten,
  output logic       owner,
  output logic       busy
);
  localparam logic [7:0] LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    GNT_MON,
    GNT_CPU
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic       owner_nx;
  logic [7:0] to_cnt;
  logic [7:0] to_cnt_nx;
  logic [7:0] wdata_nx;
  logic       wten_nx;

  logic [7:0] mon_rd;
  logic [7:0] cpu_rd;
  logic       mon_empty;
  logic       cpu_empty;
  logic       mon_pop;
  logic       cpu_pop;

  logic       sel_empty;
  logic [7:0] sel_data;
  logic       pop_ok;

  uart_tx_arb_fifo #(.DEPTH(DEPTH)) u_mon_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_data (mon_char),
    .wr_en   (mon_en),
    .rd_en   (mon_pop),
    .rd_data (mon_rd),
    .full    (mon_full),
    .empty   (mon_empty)
  );

  uart_tx_arb_fifo #(.DEPTH(DEPTH)) u_cpu_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_data (cpu_char),
    .wr_en   (cpu_en),
    .rd_en   (cpu_pop),
    .rd_data (cpu_rd),
    .full    (cpu_full),
    .empty   (cpu_empty)
  );

  // The !tx_wten term leaves uart_if one cycle to raise tx_fifo_full.
  assign pop_ok    = !tx_fifo_full && !tx_wten;
  assign sel_empty = (state == GNT_CPU) ? cpu_empty : mon_empty;
  assign sel_data  = (state == GNT_CPU) ? cpu_rd : mon_rd;
  assign busy      = (state != IDLE);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nx  = state;
    owner_nx  = owner;
    to_cnt_nx = to_cnt;
    wdata_nx  = tx_wdata;
    wten_nx   = 1'b0;
    mon_pop   = 1'b0;
    cpu_pop   = 1'b0;

    case (state)
      IDLE: begin
        to_cnt_nx = '0;
        // On a tie the requester that did not hold the last grant wins.
        if (!mon_empty && (cpu_empty || owner)) begin
          state_nx = GNT_MON;
          owner_nx = 1'b0;
        end else if (!cpu_empty) begin
          state_nx = GNT_CPU;
          owner_nx = 1'b1;
        end
      end

      GNT_MON, GNT_CPU: begin
        if (!sel_empty && pop_ok) begin
          mon_pop   = (state == GNT_MON);
          cpu_pop   = (state == GNT_CPU);
          wten_nx   = 1'b1;
          wdata_nx  = sel_data;
          to_cnt_nx = '0;
          if (sel_data == LF) state_nx = IDLE;
        end else if (sel_empty) begin
          if (to_cnt == 8'(HOLD_TO - 1)) begin
            state_nx  = IDLE;
            to_cnt_nx = '0;
          end else begin
            to_cnt_nx = to_cnt + 1'b1;
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= 1'b1;
      to_cnt   <= '0;
      tx_wdata <= 8'h00;
      tx_wten  <= 1'b0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      to_cnt   <= to_cnt_nx;
      tx_wdata <= wdata_nx;
      tx_wten  <= wten_nx;
    end
  end
endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Transmit-side arbiter that shares the single UART TX FIFO write port (`tx_wdata`/`tx_wten` into `uart_if`) between two character sources: the monitor's `uart_send_char` output and a CPU-side console port. Each source has a small private character FIFO, and grants are line-atomic, so text lines from the two sources never interleave. The block sits between the monitor and CPU character producers and `uart_if`, replacing the direct `send_char`/`send_en` connection.

## Interface
- `DEPTH`, 4: entries per requester FIFO; power of two, ≥2.
- `HOLD_TO`, 255: idle cycles before a granted requester with an empty FIFO loses the grant; range 1..255.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `mon_char` in 8: monitor character.
- `mon_en` in 1: monitor write strobe, one character per cycle.
- `mon_full` out 1: monitor FIFO full.
- `cpu_char` in 8: CPU console character.
- `cpu_en` in 1: CPU write strobe.
- `cpu_full` out 1: CPU FIFO full.
- `tx_fifo_full` in 1: UART TX FIFO full, from `uart_if`.
- `tx_wdata` out 8: character to the UART TX FIFO.
- `tx_wten` out 1: single-cycle write strobe to the UART TX FIFO.
- `owner` out 1: current or last grant; 0 = monitor, 1 = CPU.
- `busy` out 1: FSM is not in IDLE.

## Operation
- **Requester FIFOs.** Each requester has a `DEPTH`-entry FIFO.
  - `x_full` = (count == `DEPTH`), computed from the registered count.
  - `x_en` while `x_full` is high drops the character; the count is unchanged.
  - A push and a pop in the same cycle are allowed when the FIFO is not full; the count is then unchanged.
  - Read and write pointers wrap modulo `DEPTH`.
- **FSM states:** IDLE, GNT_MON, GNT_CPU.
- **IDLE:**
  - If exactly one FIFO is non-empty, go to that requester's GNT state.
  - If both are non-empty, grant the requester that is not `owner` (round-robin).
  - Reset value of `owner` is 1, so the monitor wins the first tie.
  - `owner` updates on entry to a GNT state.
- **GNT_x pop rule:**
  - Pop condition: FIFO_x non-empty && !`tx_fifo_full` && !`tx_wten`.
  - On a pop, `tx_wdata` <= popped character and `tx_wten` <= 1, both registered. Otherwise `tx_wten` <= 0.
  - The `!tx_wten` term limits output to one character every 2 cycles. This gives `uart_if` one cycle to update `tx_fifo_full`, so the TX FIFO can never overrun.
- **Release:**
  - If the popped character is 8'h0A (LF), return to IDLE on the same edge.
  - Timeout counter: clears on every pop; increments while FIFO_x is empty; holds while FIFO_x is non-empty but stalled by `tx_fifo_full` or `tx_wten`.
  - When the counter reaches `HOLD_TO`, return to IDLE and clear the counter.
- **Non-owner traffic.** The other requester's FIFO keeps accepting writes while not granted, until it is full.
- **Reset.** Asserting `rst_n` mid-operation clears all state immediately:
  - FIFOs empty and pointers 0.
  - FSM in IDLE, timeout counter 0.
  - `tx_wten` 0, `tx_wdata` 8'h00, `owner` 1, `busy` 0, `mon_full` 0, `cpu_full` 0.
  - Queued characters are lost.

## Timing
- **Idle latency.** With `x_en` high in cycle 0 and the block idle:
  - Cycle 1: FIFO non-empty; FSM leaves IDLE at the end of cycle 1.
  - Cycle 2: pop.
  - Cycle 3: `tx_wten` high.
- **Within a grant.** Back-to-back characters appear on `tx_wten` in cycles 3, 5, 7, … while `tx_fifo_full` stays low.
- **Re-grant after LF.** LF is written in cycle k (pop in k−1); the FSM is in IDLE in cycle k. The next grant's first `tx_wten` occurs in cycle k+2 at the earliest.
- **Back-pressure.** `tx_fifo_full` is sampled in the pop cycle. When it is high, no pop occurs and `tx_wten` is low in the following cycle.
- **`busy`** equals (state != IDLE), registered with the state.

## Test plan
- **Single requester:** monitor writes "AB\n" (41, 42, 0A) from idle → `tx_wten` in cycles 3, 5, 7 with data 41, 42, 0A; `busy` drops in cycle 7; `owner` = 0.
- **Tie and atomicity:** both FIFOs loaded in the same cycle (mon "X\n", cpu "Y\n") → output order 58, 0A, 59, 0A; the second line starts no earlier than 2 cycles after the first LF; `owner` goes 0 then 1.
- **Overflow:** `DEPTH`=4, 6 consecutive `cpu_en` cycles while the monitor holds the grant and is stalled → `cpu_full` high after the 4th write; only the first 4 characters are later emitted.
- **Timeout:** CPU sends "Z" with no LF, monitor queues "M\n" → 5A emitted; after `HOLD_TO` (255) empty cycles the grant releases and 4D, 0A follow.
- **TX back-pressure:** hold `tx_fifo_full` = 1 for 20 cycles mid-line → no `tx_wten` during the hold; timeout does not expire; output resumes 2 cycles after release with no character lost or duplicated.
- **Reset mid-line:** pull `rst_n` low while 3 characters are queued → outputs go immediately to their reset values; after release, no stale character is emitted.
